// File: rtl/fp32_pkg.sv
// Shared binary32 definitions for the FPU datapath (adder and float-to-int converter).
package fp32_pkg;

  localparam int FP_BIAS   = 127;
  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 23;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_FRAC_W-1:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} f2i_state_e;

endpackage

// File: rtl/fp32_unpack.sv
// Combinational binary32 classifier plus signed unbiased exponent; shared with the adder front end.
module fp32_unpack
  import fp32_pkg::*;
(
  input  fp32_t             a,
  output logic              is_zero,
  output logic              is_denorm,
  output logic              is_inf,
  output logic              is_nan,
  output logic signed [9:0] exp_unb
);

  logic exp_zero;
  logic exp_ones;
  logic frac_zero;

  assign exp_zero  = (a.exp == '0);
  assign exp_ones  = (a.exp == '1);
  assign frac_zero = (a.frac == '0);

  assign is_zero   = exp_zero & frac_zero;
  assign is_denorm = exp_zero & ~frac_zero;
  assign is_inf    = exp_ones & frac_zero;
  assign is_nan    = exp_ones & ~frac_zero;
  assign exp_unb   = signed'({2'b00, a.exp} - 10'(FP_BIAS));

endmodule

// File: rtl/fp32_to_int32_seq.sv
// Iterative binary32 -> signed int32 converter with a STEP-bit-per-cycle denormalizing shifter.
// Define FP2INT_RNE_EN for round-to-nearest-even; otherwise results truncate toward zero.
module fp32_to_int32_seq
  import fp32_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_res,
  output logic        out_ovf,
  output logic        out_inexact,
  output f2i_state_e  dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready; the
  // producer holds valid and data stable until that edge.

  fp32_t             a;
  logic              is_zero, is_denorm, is_inf, is_nan;
  logic signed [9:0] exp_unb;

  assign a = fp32_t'(in_a);

  fp32_unpack u_unpack (
    .a        (a),
    .is_zero  (is_zero),
    .is_denorm(is_denorm),
    .is_inf   (is_inf),
    .is_nan   (is_nan),
    .exp_unb  (exp_unb)
  );

  f2i_state_e  state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic        guard_q, guard_d, sticky_q, sticky_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        left_q, left_d, sign_q, sign_d;
  logic        force_q, force_d, fovf_q, fovf_d;
  logic [31:0] fres_q, fres_d;
  logic        out_valid_q, out_valid_d, out_ovf_q, out_ovf_d, out_inexact_q, out_inexact_d;
  logic [31:0] out_res_q, out_res_d;

  logic [4:0]  n;
  logic [31:0] mag_v;
  logic        guard_v, sticky_v;
  logic [32:0] rnd;

  always_comb begin
    state_d       = state_q;
    mag_d         = mag_q;
    guard_d       = guard_q;
    sticky_d      = sticky_q;
    cnt_d         = cnt_q;
    left_d        = left_q;
    sign_d        = sign_q;
    force_d       = force_q;
    fovf_d        = fovf_q;
    fres_d        = fres_q;
    out_valid_d   = out_valid_q;
    out_res_d     = out_res_q;
    out_ovf_d     = out_ovf_q;
    out_inexact_d = out_inexact_q;
    n             = (cnt_q < 5'(STEP)) ? cnt_q : 5'(STEP);
    mag_v         = mag_q;
    guard_v       = guard_q;
    sticky_v      = sticky_q;
    rnd           = {1'b0, mag_q};

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d   = a.sign;
          mag_d    = {8'b0, 1'b1, a.frac};
          guard_d  = 1'b0;
          sticky_d = 1'b0;
          force_d  = 1'b0;
          fovf_d   = 1'b0;
          fres_d   = '0;
          cnt_d    = '0;
          left_d   = 1'b0;
          state_d  = ROUND;
          if (is_nan) begin
            force_d = 1'b1;
            fovf_d  = 1'b1;
            fres_d  = 32'h7FFF_FFFF;
          end else if (is_inf || exp_unb >= 10'sd31) begin
            force_d = 1'b1;
            // -2^31 is the one out-of-range magnitude that int32 represents exactly
            fovf_d  = !(a.sign && exp_unb == 10'sd31 && a.frac == '0);
            fres_d  = a.sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
          end else if (is_zero || is_denorm) begin
            mag_d    = '0;
            sticky_d = is_denorm;
          end else if (exp_unb < -10'sd1) begin
            mag_d    = '0;
            sticky_d = 1'b1;
          end else if (exp_unb >= 10'sd23) begin
            left_d = 1'b1;
            cnt_d  = 5'(exp_unb - 10'sd23);
            if (cnt_d != '0) state_d = SHIFT;
          end else begin
            cnt_d = 5'(10'sd23 - exp_unb);
            if (cnt_d != '0) state_d = SHIFT;
          end
        end
      end

      SHIFT: begin
        if (left_q) begin
          mag_v = mag_q << n;
        end else begin
          for (int i = 0; i < STEP; i++) begin
            if (5'(i) < n) begin
              sticky_v = sticky_v | guard_v;
              guard_v  = mag_v[0];
              mag_v    = mag_v >> 1;
            end
          end
        end
        mag_d    = mag_v;
        guard_d  = guard_v;
        sticky_d = sticky_v;
        cnt_d    = cnt_q - n;
        if (cnt_d == '0) state_d = ROUND;
      end

      ROUND: begin
`ifdef FP2INT_RNE_EN
        rnd = {1'b0, mag_q} + {32'b0, guard_q & (sticky_q | mag_q[0])};
`else
        rnd = {1'b0, mag_q};
`endif
        out_inexact_d = guard_q | sticky_q;
        out_ovf_d     = 1'b0;
        if (force_q) begin
          out_res_d = fres_q;
          out_ovf_d = fovf_q;
        end else begin
          if (rnd > 33'h0_7FFF_FFFF) begin
            rnd       = 33'h0_7FFF_FFFF;
            out_ovf_d = 1'b1;
          end
          out_res_d = sign_q ? (~rnd[31:0] + 32'd1) : rnd[31:0];
        end
        out_valid_d = 1'b1;
        state_d     = DONE;
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      mag_q         <= '0;
      guard_q       <= 1'b0;
      sticky_q      <= 1'b0;
      cnt_q         <= '0;
      left_q        <= 1'b0;
      sign_q        <= 1'b0;
      force_q       <= 1'b0;
      fovf_q        <= 1'b0;
      fres_q        <= '0;
      out_valid_q   <= 1'b0;
      out_res_q     <= '0;
      out_ovf_q     <= 1'b0;
      out_inexact_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mag_q         <= mag_d;
      guard_q       <= guard_d;
      sticky_q      <= sticky_d;
      cnt_q         <= cnt_d;
      left_q        <= left_d;
      sign_q        <= sign_d;
      force_q       <= force_d;
      fovf_q        <= fovf_d;
      fres_q        <= fres_d;
      out_valid_q   <= out_valid_d;
      out_res_q     <= out_res_d;
      out_ovf_q     <= out_ovf_d;
      out_inexact_q <= out_inexact_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = out_valid_q;
  assign out_res     = out_res_q;
  assign out_ovf     = out_ovf_q;
  assign out_inexact = out_inexact_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fp32_to_int32_seq.sv
// Scoreboard bench for fp32_to_int32_seq: directed vectors, expected queue, decoupled monitor.
module tb_fp32_to_int32_seq;
  import fp32_pkg::*;

  localparam int STEP = 1;
`ifdef FP2INT_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_res;
  logic        out_ovf;
  logic        out_inexact;
  f2i_state_e  dbg_state;

  fp32_to_int32_seq #(.STEP(STEP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_res    (out_res),
    .out_ovf    (out_ovf),
    .out_inexact(out_inexact),
    .dbg_state  (dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  logic [33:0] exp_q[$];
  string       name_q[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, req);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [33:0] e;
    string       nm;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_output: got res=%h ovf=%b inexact=%b expected no output",
                 out_res, out_ovf, out_inexact);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check(nm, {30'b0, out_res, out_ovf, out_inexact}, {30'b0, e});
      end
    end
  end

  // driver: called just after a rising edge, returns just after the accept edge
  task automatic send(input string nm, input logic [31:0] a, input logic [31:0] r,
                      input logic o, input logic x, input bit push);
    int t;
    t        = 0;
    in_valid = 1'b1;
    in_a     = a;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      $display("FAIL %s_accept: got in_ready=0 after %0d cycles expected 1", nm, t);
      in_valid = 1'b0;
      return;
    end
    if (push) begin
      exp_q.push_back({r, o, x});
      name_q.push_back(nm);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = $urandom;
  endtask

  task automatic send_lat(input string nm, input logic [31:0] a, input logic [31:0] r,
                          input logic o, input logic x, input int lat);
    int n;
    send(nm, a, r, o, x, 1'b1);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 100);
    check({nm, "_latency"}, 64'(n), 64'(lat));
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || !in_ready) && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 500) begin
      checks++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {27'b0, out_valid, in_ready, out_ovf, out_inexact, out_res, 2'(dbg_state)},
          {27'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 2'(IDLE)});
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send("one_p5",      32'h3FC0_0000, RNE ? 32'd2 : 32'd1, 1'b0, 1'b1, 1'b1);
    send("two_p5",      32'h4020_0000, 32'd2,                1'b0, 1'b1, 1'b1);
    send("three_p5",    32'h4060_0000, RNE ? 32'd4 : 32'd3, 1'b0, 1'b1, 1'b1);
    send("neg_three_p5",32'hC060_0000, RNE ? 32'hFFFF_FFFC : 32'hFFFF_FFFD, 1'b0, 1'b1, 1'b1);
    send("half",        32'h3F00_0000, 32'd0,                1'b0, 1'b1, 1'b1);
    send("three_qtr",   32'h3F40_0000, RNE ? 32'd1 : 32'd0, 1'b0, 1'b1, 1'b1);
    send("quarter",     32'h3E80_0000, 32'd0,                1'b0, 1'b1, 1'b1);
    send("pos_2p31",    32'h4F00_0000, 32'h7FFF_FFFF,        1'b1, 1'b0, 1'b1);
    send("neg_2p31",    32'hCF00_0000, 32'h8000_0000,        1'b0, 1'b0, 1'b1);
    send("neg_big",     32'hCF00_0001, 32'h8000_0000,        1'b1, 1'b0, 1'b1);
    send("qnan",        32'h7FC0_0000, 32'h7FFF_FFFF,        1'b1, 1'b0, 1'b1);
    send("pos_inf",     32'h7F80_0000, 32'h7FFF_FFFF,        1'b1, 1'b0, 1'b1);
    send("neg_inf",     32'hFF80_0000, 32'h8000_0000,        1'b1, 1'b0, 1'b1);
    send("min_denorm",  32'h0000_0001, 32'd0,                1'b0, 1'b1, 1'b1);
    send("pos_zero",    32'h0000_0000, 32'd0,                1'b0, 1'b0, 1'b1);
    send("neg_zero",    32'h8000_0000, 32'd0,                1'b0, 1'b0, 1'b1);
    wait_drain();

    send_lat("neg_123",   32'hC2F6_0000, 32'hFFFF_FF85, 1'b0, 1'b0, (17 + STEP - 1) / STEP + 1);
    send_lat("max_left",  32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, (7 + STEP - 1) / STEP + 1);
    send_lat("no_shift",  32'h4B00_0001, 32'h0080_0001, 1'b0, 1'b0, 1);
    wait_drain();

    // downstream stall holds the result
    out_ready = 1'b0;
    send("stall_1p5", 32'h3FC0_0000, RNE ? 32'd2 : 32'd1, 1'b0, 1'b1, 1'b1);
    t = 0;
    while (!out_valid && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (5) begin
      @(negedge clk);
      check("stall_hold", {30'b0, out_valid, in_ready, out_res},
            {30'b0, 1'b1, 1'b0, RNE ? 32'd2 : 32'd1});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send("b2b_pos_one", 32'h3F80_0000, 32'd1,         1'b0, 1'b0, 1'b1);
    send("b2b_neg_one", 32'hBF80_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    wait_drain();

    // reset abort mid-shift
    send("abort", 32'hC2F6_0000, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("abort_in_shift", 64'(dbg_state), 64'(SHIFT));
    rst_n = 1'b0;
    #1;
    check("abort_reset", {28'b0, out_valid, in_ready, out_ovf, out_inexact, out_res},
          {28'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_lat("post_abort", 32'hC2F6_0000, 32'hFFFF_FF85, 1'b0, 1'b0, (17 + STEP - 1) / STEP + 1);
    wait_drain();
    repeat (3) @(posedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
